// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-length constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b010,
      PARITY = 3'b011,
      STOP   = 3'b100
   } uart_state_t;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 1 + DATA_BITS + 1 + 1;

   function automatic logic exp_parity(
      input logic [DATA_BITS-1:0] d,
      input logic                 odd
   );
      return odd ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: received byte, completion pulse, status flags.
// The receiver drives it through the master modport.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output rx_busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input parity_err,
      input frame_err,
      input rx_busy
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset high so an idle line is never seen as a start bit.
module uart_sync2 (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic q1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         q1 <= 1'b1;
         q  <= 1'b1;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Bits are sampled mid-cell; the frame is reported at the stop-bit middle.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      rx_line,
   input  logic      parity_mode,
   uart_rx_if.master bus
);

   localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CW       = $clog2(BIT_CYC);

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

   uart_state_t          state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [2:0]           idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 pend, pend_n;
   logic                 armed, armed_n;
   logic [DATA_BITS-1:0] data_q, data_n;
   logic                 valid_q, valid_n;
   logic                 perr_q, perr_n;
   logic                 ferr_q, ferr_n;
   logic                 rx_s;
   logic                 bit_end;

   uart_sync2 u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rx_line),
      .q    (rx_s)
   );

   assign bit_end = (cnt == BIT_LAST);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      pend_n  = pend;
      armed_n = armed;
      data_n  = data_q;
      valid_n = 1'b0;
      perr_n  = perr_q;
      ferr_n  = ferr_q;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (rx_s)
               armed_n = 1'b1;
            else if (armed)
               state_n = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               sh_n[idx] = rx_s;
               cnt_n     = '0;
               idx_n     = idx + 3'd1;
               if (idx == 3'd7)
                  state_n = PARITY;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               pend_n  = rx_s != exp_parity(sh, parity_mode);
               cnt_n   = '0;
               state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            // leave at mid-stop so a following start edge is not missed
            if (bit_end) begin
               cnt_n   = '0;
               state_n = IDLE;
               armed_n = rx_s;
               valid_n = 1'b1;
               data_n  = sh;
               perr_n  = pend;
               ferr_n  = ~rx_s;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         pend    <= 1'b0;
         armed   <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         sh      <= sh_n;
         pend    <= pend_n;
         armed   <= armed_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         perr_q  <= perr_n;
         ferr_q  <= ferr_n;
      end
   end

   assign bus.rx_data    = data_q;
   assign bus.rx_valid   = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.rx_busy    = (state != IDLE);

endmodule
